bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/rr_arbiter3.sv | 36 +++
 rtl/bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: FSM state encoding and client indices.
package bus_arbiter_pkg;

  typedef enum logic [3:0] {
    IDLE, RAM_SETUP, RAM_STROBE, RAM_END,
    TX_SETUP, TX_STROBE, TX_TBRE, TX_TSRE,
    RX_POLL, RX_STROBE, RX_CAPTURE, TURN
  } state_t;

  localparam int NUM_CLI = 3;
  localparam int CLI_RAM = 0;
  localparam int CLI_TX  = 1;
  localparam int CLI_RX  = 2;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, pointer moves
// past the granted client when advance is asserted.
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);

  logic [1:0] ptr;
  logic [2:0] rot, rot_g;

  // Rotate so the highest-priority client sits at bit 0, pick lowest set bit, rotate back.
  always_comb begin
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    rot_g = rot & (~rot + 3'd1);
    case (ptr)
      2'd1:    grant = {rot_g[1], rot_g[0], rot_g[2]};
      2'd2:    grant = {rot_g[0], rot_g[2], rot_g[1]};
      default: grant = rot_g;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= 2'd0;
    else if (advance && (|grant))
      ptr <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter for RAM1 and a UART; one transaction per grant, always closed by a TURN cycle.
// Optional TX status-wait timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STROBE_CYC  = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_req,
  input  logic        ram_we,
  input  logic [17:0] ram_addr,
  input  logic [15:0] ram_wdata,
  output logic        ram_done,
  output logic [15:0] ram_rdata,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_done,
  input  logic        rx_req,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        err,
  input  logic [15:0] bus_i,
  output logic [15:0] bus_o,
  output logic        bus_oe,
  output logic [17:0] ram1_addr,
  output logic        ram1_en,
  output logic        ram1_oe,
  output logic        ram1_we,
  output logic        wrn,
  output logic        rdn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  localparam logic [3:0] STB_LAST = 4'(STROBE_CYC - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic               we_q;
  logic [NUM_CLI-1:0] req, grant;
  logic               advance;

  always_comb begin
    req          = '0;
    req[CLI_RAM] = ram_req;
    req[CLI_TX]  = tx_req;
    req[CLI_RX]  = rx_req;
  end

  assign advance = (state == IDLE);

  rr_arbiter3 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      ram1_addr <= '0;
      ram1_en   <= 1'b1;
      ram1_oe   <= 1'b1;
      ram1_we   <= 1'b1;
      wrn       <= 1'b1;
      rdn       <= 1'b1;
      bus_o     <= '0;
      bus_oe    <= 1'b0;
      ram_rdata <= '0;
      rx_data   <= '0;
      ram_done  <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      tmo       <= '0;
      err       <= 1'b0;
`endif
    end else begin
      ram_done <= 1'b0;
      tx_done  <= 1'b0;
      rx_valid <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      err      <= 1'b0;
      tmo      <= tmo + 16'd1;
`endif
      case (state)
        IDLE: begin
          // Client inputs are captured here; later changes have no effect.
          if (grant[CLI_RAM]) begin
            state     <= RAM_SETUP;
            we_q      <= ram_we;
            ram1_addr <= ram_addr;
            ram1_en   <= 1'b0;
            if (ram_we) begin
              bus_o  <= ram_wdata;
              bus_oe <= 1'b1;
            end
          end else if (grant[CLI_TX]) begin
            state  <= TX_SETUP;
            bus_o  <= {8'h00, tx_data};
            bus_oe <= 1'b1;
          end else if (grant[CLI_RX]) begin
            state <= RX_POLL;
          end
        end
        RAM_SETUP: begin
          state <= RAM_STROBE;
          cnt   <= STB_LAST;
          if (we_q) ram1_we <= 1'b0;
          else      ram1_oe <= 1'b0;
        end
        RAM_STROBE: begin
          if (cnt == 4'd0) begin
            state    <= RAM_END;
            ram1_we  <= 1'b1;
            ram1_oe  <= 1'b1;
            ram1_en  <= 1'b1;
            ram_done <= 1'b1;
            if (!we_q) ram_rdata <= bus_i;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RAM_END: begin
          state  <= TURN;
          bus_oe <= 1'b0;
        end
        TX_SETUP: begin
          state <= TX_STROBE;
          wrn   <= 1'b0;
          cnt   <= STB_LAST;
        end
        TX_STROBE: begin
          if (cnt == 4'd0) begin
            state  <= TX_TBRE;
            wrn    <= 1'b1;
            bus_oe <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo    <= '0;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TX_TBRE: begin
          if (tbre) begin
            state <= TX_TSRE;
`ifdef BUS_ARBITER_TIMEOUT_EN
            tmo   <= '0;
          end else if (tmo == TMO_LAST) begin
            state <= TURN;
            err   <= 1'b1;
`endif
          end
        end
        TX_TSRE: begin
          if (tsre) begin
            state   <= TURN;
            tx_done <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
          end else if (tmo == TMO_LAST) begin
            state <= TURN;
            err   <= 1'b1;
`endif
          end
        end
        RX_POLL: begin
          if (!data_ready) begin
            state <= TURN;
          end else begin
            state <= RX_STROBE;
            rdn   <= 1'b0;
            cnt   <= STB_LAST;
          end
        end
        RX_STROBE: begin
          // Capture on the last low cycle so the UART is still driving.
          if (cnt == 4'd0) begin
            state    <= RX_CAPTURE;
            rx_data  <= bus_i[7:0];
            rdn      <= 1'b1;
            rx_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RX_CAPTURE: state <= TURN;
        TURN:       state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expectations queued at stimulus, popped on done/valid pulses.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ram_req = 0, ram_we = 0, tx_req = 0, rx_req = 0;
  logic [17:0] ram_addr = '0;
  logic [15:0] ram_wdata = '0, bus_i = '0;
  logic [7:0]  tx_data = '0;
  logic        data_ready = 0, tbre = 0, tsre = 0;
  logic        ram_done, tx_done, rx_valid, err, bus_oe;
  logic        ram1_en, ram1_oe, ram1_we, wrn, rdn;
  logic [15:0] ram_rdata, bus_o;
  logic [7:0]  rx_data;
  logic [17:0] ram1_addr;

  bus_arbiter #(.STROBE_CYC(2), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_done(ram_done), .ram_rdata(ram_rdata),
    .tx_req(tx_req), .tx_data(tx_data), .tx_done(tx_done),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .bus_i(bus_i), .bus_o(bus_o), .bus_oe(bus_oe),
    .ram1_addr(ram1_addr), .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
    .wrn(wrn), .rdn(rdn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  always #5 clk = ~clk;

  typedef struct { int cli; logic [15:0] data; } exp_t;
  exp_t        sb[$];
  int          errors = 0, checks = 0, overlap = 0;
  logic [15:0] strobe_data = '0;

  always @(negedge clk) begin
    if (rst && !ram1_en && (!wrn || !rdn)) overlap++;
    if (!ram1_we || !wrn) strobe_data = bus_o;
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wrn, rdn, ram1_en, ram1_oe, ram1_we, bus_oe, ram_done, tx_done, rx_valid, err} !== 10'b1111100000 ||
        bus_o !== 16'h0 || ram1_addr !== 18'h0 || ram_rdata !== 16'h0 || rx_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b bus_o=%h addr=%h rdata=%h rx_data=%h, want ctl=1111100000 and zeros",
               {wrn, rdn, ram1_en, ram1_oe, ram1_we, bus_oe, ram_done, tx_done, rx_valid, err},
               bus_o, ram1_addr, ram_rdata, rx_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ram_write();
    int we_low = 0, bad = 0, done_at = -1;
    exp_t e;
    ram_req = 1; ram_we = 1; ram_addr = 18'h00010; ram_wdata = 16'hA55A;
    sb.push_back('{CLI_RAM, 16'hA55A});
    for (int i = 1; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin ram_req = 0; ram_addr = 18'h3FFFF; ram_wdata = 16'h0000; end
      if (!ram1_we) begin
        we_low++;
        if (bus_o !== 16'hA55A || !bus_oe || ram1_addr !== 18'h00010 || ram1_en) bad++;
      end
      if (ram_done) begin
        done_at = i;
        e = sb.pop_front();
        checks++;
        if (strobe_data !== e.data) begin
          errors++; $display("FAIL ram_wr_data: got %h want %h", strobe_data, e.data);
        end
      end
    end
    checks++;
    if (done_at < 0) begin errors++; $display("FAIL ram_wr_done: no ram_done within 20 cycles"); end
    checks++;
    if (we_low != 2) begin errors++; $display("FAIL ram_wr_strobe_len: ram1_we low %0d cycles want 2", we_low); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ram_wr_bus: %0d strobe cycles with wrong bus/addr/en", bad); end
    @(negedge clk);
    checks++;
    if (ram_done || bus_oe || !ram1_en || !ram1_we || !ram1_oe) begin
      errors++; $display("FAIL ram_wr_turn: done=%b oe=%b en=%b we=%b ram1_oe=%b want 0,0,1,1,1",
                         ram_done, bus_oe, ram1_en, ram1_we, ram1_oe);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ram_read();
    int oe_low = 0, we_low = 0, done = 0;
    exp_t e;
    ram_req = 1; ram_we = 0; ram_addr = 18'h2ABCD; bus_i = 16'hBEEF;
    sb.push_back('{CLI_RAM, 16'hBEEF});
    for (int i = 1; i < 20 && !done; i++) begin
      @(negedge clk);
      ram_req = 0;
      if (!ram1_oe) oe_low++;
      if (!ram1_we || bus_oe) we_low++;
      if (ram_done) begin
        done = 1;
        e = sb.pop_front();
        checks++;
        if (ram_rdata !== e.data) begin
          errors++; $display("FAIL ram_rd_data: got %h want %h", ram_rdata, e.data);
        end
      end
    end
    checks++;
    if (!done || oe_low != 2 || we_low != 0) begin
      errors++; $display("FAIL ram_rd_strobe: done=%0d oe_low=%0d want 2, write/drive cycles=%0d want 0",
                         done, oe_low, we_low);
    end
    bus_i = 16'h0; repeat (3) @(negedge clk);
  endtask

  task automatic test_tx();
    int wrn_low = 0, bad = 0, done_at = -1;
    exp_t e;
    tbre = 0; tsre = 0;
    tx_req = 1; tx_data = 8'h41;
    sb.push_back('{CLI_TX, 16'h0041});
    for (int i = 1; i < 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin tx_req = 0; tx_data = 8'hFF; end
      if (!wrn) begin wrn_low++; if (bus_o !== 16'h0041 || !bus_oe) bad++; end
      if (tx_done) begin
        done_at = i;
        e = sb.pop_front();
        checks++;
        if (strobe_data !== e.data) begin
          errors++; $display("FAIL tx_data: bus during wrn got %h want %h", strobe_data, e.data);
        end
        checks++;
        if (bus_oe || !wrn || !rdn || !ram1_en) begin
          errors++; $display("FAIL tx_turn: oe=%b wrn=%b rdn=%b en=%b want 0,1,1,1", bus_oe, wrn, rdn, ram1_en);
        end
      end
      tbre = (i >= 5); tsre = (i >= 10);
    end
    checks++;
    if (done_at != 11) begin errors++; $display("FAIL tx_done_time: at cycle %0d want 11", done_at); end
    checks++;
    if (wrn_low != 2 || bad != 0) begin
      errors++; $display("FAIL tx_strobe: wrn low %0d want 2, bad bus cycles %0d", wrn_low, bad);
    end
    @(negedge clk);
    checks++;
    if (tx_done) begin errors++; $display("FAIL tx_pulse_width: tx_done still 1"); end
    tbre = 0; tsre = 0; repeat (2) @(negedge clk);
  endtask

  task automatic test_rx();
    int rdn_low = 0, spur = 0, done = 0;
    exp_t e;
    data_ready = 0; bus_i = 16'h0037; rx_req = 1;
    repeat (10) begin
      @(negedge clk);
      if (!rdn) rdn_low++;
      if (rx_valid) spur++;
    end
    checks++;
    if (rdn_low != 0 || spur != 0) begin
      errors++; $display("FAIL rx_not_ready: rdn low %0d valid %0d want 0,0", rdn_low, spur);
    end
    data_ready = 1;
    sb.push_back('{CLI_RX, 16'h0037});
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!rdn) begin rdn_low++; rx_req = 0; end
      if (rx_valid) begin
        done = 1;
        e = sb.pop_front();
        checks++;
        if ({8'h00, rx_data} !== e.data || !rdn) begin
          errors++; $display("FAIL rx_data: got %h rdn=%b want %h rdn=1", rx_data, rdn, e.data);
        end
      end
    end
    checks++;
    if (!done || rdn_low != 2) begin
      errors++; $display("FAIL rx_strobe: valid=%0d rdn low %0d want 1,2", done, rdn_low);
    end
    rx_req = 0; data_ready = 0; bus_i = 16'h0; repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n = 0, ocli;
    logic [15:0] odata;
    exp_t e;
    rst = 0; @(negedge clk); rst = 1; @(negedge clk);
    overlap = 0;
    tbre = 1; tsre = 1; data_ready = 1; bus_i = 16'h1234; ram_we = 0; tx_data = 8'h5A; ram_addr = 18'h00042;
    sb.push_back('{CLI_RAM, 16'h1234}); sb.push_back('{CLI_TX, 16'h005A});
    sb.push_back('{CLI_RX, 16'h0034});  sb.push_back('{CLI_RAM, 16'h1234});
    ram_req = 1; tx_req = 1; rx_req = 1;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (ram_done || tx_done || rx_valid) begin
        ocli  = ram_done ? CLI_RAM : (tx_done ? CLI_TX : CLI_RX);
        odata = ram_done ? ram_rdata : (tx_done ? strobe_data : {8'h00, rx_data});
        e = sb.pop_front();
        checks++;
        if (ocli !== e.cli || odata !== e.data) begin
          errors++; $display("FAIL rr_grant%0d: client %0d data %h want client %0d data %h",
                             n, ocli, odata, e.cli, e.data);
        end
        n++;
        if (n == 4) begin ram_req = 0; tx_req = 0; rx_req = 0; end
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count: %0d transactions want 4", n); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL rr_overlap: %0d cycles with ram1_en and wrn/rdn low", overlap); end
    sb.delete();
    tbre = 0; tsre = 0; data_ready = 0; bus_i = 16'h0; repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int seen_low = 0, t0 = 0, err_at = -1, err_n = 0, txd = 0;
    tbre = 0; tsre = 0; tx_req = 1; tx_data = 8'h11;
    for (int i = 0; i < 20 && !t0; i++) begin
      @(negedge clk);
      tx_req = 0;
      if (!wrn) seen_low = 1;
      else if (seen_low) t0 = 1;
    end
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 150; k++) begin
      if (err) begin err_n++; if (err_at < 0) err_at = k; end
      if (tx_done) txd++;
      @(negedge clk);
    end
    checks++;
    if (!t0 || err_at != 100 || err_n != 1) begin
      errors++; $display("FAIL timeout_err: first err at %0d (%0d pulses) want 100 (1)", err_at, err_n);
    end
    checks++;
    if (txd != 0) begin errors++; $display("FAIL timeout_no_done: tx_done seen %0d times want 0", txd); end
`else
    for (int k = 0; k < 150; k++) begin
      if (err) err_n++;
      if (tx_done) txd++;
      @(negedge clk);
    end
    checks++;
    if (!t0 || err_n != 0 || txd != 0) begin
      errors++; $display("FAIL wait_forever: err %0d tx_done %0d want 0,0", err_n, txd);
    end
    tbre = 1; tsre = 1;
    for (int k = 0; k < 10 && txd == 0; k++) begin @(negedge clk); if (tx_done) txd++; end
    checks++;
    if (txd != 1) begin errors++; $display("FAIL wait_release: tx_done %0d want 1", txd); end
`endif
    tbre = 0; tsre = 0; repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int found = 0, spur = 0;
    ram_req = 1; ram_we = 1; ram_addr = 18'h00100; ram_wdata = 16'h5555;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      ram_req = 0;
      found = !ram1_we;
    end
    #1 rst = 0;
    #1;
    checks++;
    if (!found || {ram1_we, ram1_oe, ram1_en, wrn, rdn, bus_oe} !== 6'b111110) begin
      errors++; $display("FAIL reset_mid: strobe_seen=%0d we,oe,en,wrn,rdn,bus_oe=%b want 111110",
                         found, {ram1_we, ram1_oe, ram1_en, wrn, rdn, bus_oe});
    end
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (10) begin @(negedge clk); if (ram_done) spur++; end
    checks++;
    if (spur != 0) begin errors++; $display("FAIL reset_mid_done: ram_done %0d want 0", spur); end
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_ram_read();
    test_tx();
    test_rx();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL overlap_total: %0d cycles", overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
